// File: rtl/afifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: Gray/binary
// conversion on a fixed-width carrier type and the depth calculation.
package afifo_pkg;

   // Widest pointer supported (ADDR_W up to 10, plus the wrap bit).
   localparam int MAX_PTR_W = 11;

   // Narrower pointers are zero-extended into this type; the zero upper bits
   // leave both conversions below unaffected, so one function serves all widths.
   typedef logic [MAX_PTR_W-1:0] ptr_t;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/afifo_wr_ctrl_gray_ptr.sv
// Binary + Gray pointer pair with next-state outputs. The Gray value is
// registered directly, so exactly one bit of gray_q changes per increment.
module gray_ptr
   import afifo_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] bin_q,
   output logic [W-1:0] gray_q,
   output logic [W-1:0] bin_n,
   output logic [W-1:0] gray_n
);

   // Next-state pointer values; wrap at 2**W is the natural modulo of the adder.
   always_comb begin
      bin_n  = bin_q + W'(inc);
      gray_n = W'(bin2gray(ptr_t'(bin_n)));
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_n;
         gray_q <= gray_n;
      end
   end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the Gray-pointer async FIFO: producer handshake,
// write pointer, read-pointer synchroniser and registered full/afull/level.
module afifo_wr_ctrl
   import afifo_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int AFULL_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_ptr_gray,
   input  logic [ADDR_W:0]   rd_ptr_gray,
   output logic              full,
   output logic              afull,
   output logic [ADDR_W:0]   wr_level
);

   localparam int PW    = ADDR_W + 1;
   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_TH);

   logic          accept;
   logic [PW-1:0] wbin_q, wbin_n, wgray_q, wgray_n;
   logic [PW-1:0] rq1_q, rq2_q, rbin;
   logic [PW-1:0] level_d, level_q;
   logic          full_d, full_q, afull_d, afull_q;
   logic          unused_wbin_msb;

   // Gating with rst keeps wr_en low while reset is held, even with wr_valid high.
   assign accept = wr_valid & ~full_q & rst;

   gray_ptr #(.W(PW)) u_wptr (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept),
      .bin_q  (wbin_q),
      .gray_q (wgray_q),
      .bin_n  (wbin_n),
      .gray_n (wgray_n)
   );

   // Two-flop synchroniser for the read-domain Gray pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= rd_ptr_gray;
         rq2_q <= rq1_q;
      end
   end

   // Status from the next-state write pointer, so full lands on the edge that
   // writes the last free slot; a stale rq2 can only overstate the level.
   always_comb begin
      rbin    = PW'(gray2bin(ptr_t'(rq2_q)));
      full_d  = (wgray_n == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
      level_d = wbin_n - rbin;
      afull_d = (level_d >= AFULL_LVL);
   end

   // Registered status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         level_q <= '0;
      end else begin
         full_q  <= full_d;
         afull_q <= afull_d;
         level_q <= level_d;
      end
   end

   // The wrap bit of the binary pointer only matters through wbin_n/wgray.
   assign unused_wbin_msb = wbin_q[ADDR_W];

   assign wr_ready    = ~full_q;
   assign wr_en       = accept;
   assign wr_addr     = wbin_q[ADDR_W-1:0];
   assign wr_ptr_gray = wgray_q;
   assign full        = full_q;
   assign afull       = afull_q;
   assign wr_level    = level_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl (ADDR_W=4, AFULL_TH=2).
module tb_afifo_wr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic       wr_ready, wr_en, full, afull;
   logic [3:0] wr_addr;
   logic [4:0] wr_ptr_gray, rd_ptr_gray, wr_level;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   afifo_wr_ctrl #(.ADDR_W(4), .AFULL_TH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_ptr_gray (wr_ptr_gray),
      .rd_ptr_gray (rd_ptr_gray),
      .full        (full),
      .afull       (afull),
      .wr_level    (wr_level)
   );

   typedef struct {
      logic       valid;
      logic [4:0] rd;
      logic       en, rdy, full, afull;
      logic [4:0] lvl, gray;
      logic [3:0] addr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [4:0] rd, input logic en, input logic rdy,
                      input logic f, input logic af, input logic [4:0] lvl,
                      input logic [4:0] g, input logic [3:0] a);
      vec_t x;
      x.valid = v; x.rd = rd; x.en = en; x.rdy = rdy; x.full = f; x.afull = af;
      x.lvl = lvl; x.gray = g; x.addr = a;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Packed snapshot {en,ready,full,afull,level,gray,addr}.
   function automatic logic [31:0] snap();
      return {14'd0, wr_en, wr_ready, full, afull, wr_level, wr_ptr_gray, wr_addr};
   endfunction

   function automatic logic [31:0] pack(input logic en, input logic rdy, input logic f,
                                        input logic af, input logic [4:0] lvl,
                                        input logic [4:0] g, input logic [3:0] a);
      return {14'd0, en, rdy, f, af, lvl, g, a};
   endfunction

   function automatic logic [4:0] g5(input int b);
      logic [4:0] x;
      x = 5'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [31:0] RST_SNAP = {14'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0};

   initial begin
      int wcnt;
      int rdb;
      logic [4:0] prev;

      // Reset and fill table: 5 idle cycles, then 16 accepts and two pushes while full.
      for (int i = 0; i < 5; i++) add(0, 5'd0, 0, 1, 0, 0, 5'd0, 5'b00000, 4'd0);
      add(1, 5'd0, 1, 1, 0, 0, 5'd0,  5'b00000, 4'd0);
      add(1, 5'd0, 1, 1, 0, 0, 5'd1,  5'b00001, 4'd1);
      add(1, 5'd0, 1, 1, 0, 0, 5'd2,  5'b00011, 4'd2);
      add(1, 5'd0, 1, 1, 0, 0, 5'd3,  5'b00010, 4'd3);
      add(1, 5'd0, 1, 1, 0, 0, 5'd4,  5'b00110, 4'd4);
      add(1, 5'd0, 1, 1, 0, 0, 5'd5,  5'b00111, 4'd5);
      add(1, 5'd0, 1, 1, 0, 0, 5'd6,  5'b00101, 4'd6);
      add(1, 5'd0, 1, 1, 0, 0, 5'd7,  5'b00100, 4'd7);
      add(1, 5'd0, 1, 1, 0, 0, 5'd8,  5'b01100, 4'd8);
      add(1, 5'd0, 1, 1, 0, 0, 5'd9,  5'b01101, 4'd9);
      add(1, 5'd0, 1, 1, 0, 0, 5'd10, 5'b01111, 4'd10);
      add(1, 5'd0, 1, 1, 0, 0, 5'd11, 5'b01110, 4'd11);
      add(1, 5'd0, 1, 1, 0, 0, 5'd12, 5'b01010, 4'd12);
      add(1, 5'd0, 1, 1, 0, 0, 5'd13, 5'b01011, 4'd13);
      add(1, 5'd0, 1, 1, 0, 1, 5'd14, 5'b01001, 4'd14);
      add(1, 5'd0, 1, 1, 0, 1, 5'd15, 5'b01000, 4'd15);
      add(1, 5'd0, 0, 0, 1, 1, 5'd16, 5'b11000, 4'd0);
      add(1, 5'd0, 0, 0, 1, 1, 5'd16, 5'b11000, 4'd0);

      rst = 1'b0; wr_valid = 1'b0; rd_ptr_gray = 5'd0;
      @(negedge clk);
      #1 chk("reset_state", snap(), RST_SNAP);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         wr_valid    = vecs[i].valid;
         rd_ptr_gray = vecs[i].rd;
         #1 chk($sformatf("vec[%0d]", i), snap(),
                pack(vecs[i].en, vecs[i].rdy, vecs[i].full, vecs[i].afull,
                     vecs[i].lvl, vecs[i].gray, vecs[i].addr));
         tick();
      end

      // Read pointer moves to 1 while full: status follows only after the 3rd edge.
      wr_valid = 1'b0; rd_ptr_gray = 5'b00001;
      #1 chk("rd1_edge0", {full, wr_level}, {1'b1, 5'd16});
      for (int e = 1; e <= 3; e++) begin
         tick();
         #1;
         if (e < 3) chk($sformatf("rd1_edge%0d", e), {full, wr_level}, {1'b1, 5'd16});
         else       chk("rd1_edge3", {full, afull, wr_level}, {1'b0, 1'b1, 5'd15});
      end

      // Accept coinciding with a synchronised read advance keeps level at 15.
      rd_ptr_gray = 5'b00011;
      tick();
      #1 chk("simul_wait1", {full, wr_level}, {1'b0, 5'd15});
      tick();
      wr_valid = 1'b1;
      #1 chk("simul_accept_en", {wr_en, wr_addr}, {1'b1, 4'd0});
      tick();
      wr_valid = 1'b0;
      #1 chk("simul_after", {full, wr_level, wr_ptr_gray}, {1'b0, 5'd15, 5'b11001});
      for (int k = 0; k < 2; k++) begin
         tick();
         #1 chk($sformatf("simul_hold%0d", k), {full, wr_level}, {1'b0, 5'd15});
      end

      // Streaming with a 4-word read lag across address and pointer wrap.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wcnt = 0;
      for (int c = 0; c < 40; c++) begin
         rdb = (wcnt > 4) ? wcnt - 4 : 0;
         rd_ptr_gray = g5(rdb);
         wr_valid    = 1'b1;
         #1;
         chk($sformatf("stream_hs%0d", c), {wr_en, full, afull, wr_addr, wr_ptr_gray},
             {1'b1, 1'b0, 1'b0, 4'(wcnt % 16), g5(wcnt % 32)});
         prev = wr_ptr_gray;
         tick();
         #1;
         wcnt++;
         chk($sformatf("stream_1bit%0d", c), 32'($countones(prev ^ wr_ptr_gray)), 32'd1);
      end
      wr_valid = 1'b0;
      chk("stream_final_gray", {27'd0, wr_ptr_gray}, {27'd0, g5(40)});

      // Asynchronous reset mid-burst at level 9.
      rd_ptr_gray = 5'd0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wr_valid = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      #1 chk("burst_level9", {wr_level, wr_addr}, {5'd9, 4'd9});
      #2 rst = 1'b0;
      #1 chk("midburst_reset", snap(), RST_SNAP);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("post_reset_push", {wr_en, wr_addr}, {1'b1, 4'd0});
      tick();
      #1 chk("post_reset_ptr", {27'd0, wr_ptr_gray}, {27'd0, 5'b00001});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
